// File: rtl/mem_complete_buffer_if.sv
// Handshake bundle between the memory/LSQ result sources, the completion buffer and the complete stage.
// Extra per-source load-extension fields exist only when LOAD_EXT_EN is defined.
interface mem_complete_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned DEPTH = 4
);
  logic                       lsq_valid;
  logic                       lsq_ready;
  logic [XLEN-1:0]            lsq_data;
  logic [XLEN-1:0]            lsq_pc;
  logic [TAG_W-1:0]           lsq_tag;
  logic                       lsq_wr_flag;
  logic                       lsq_rd_flag;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [XLEN-1:0]            mem_data;
  logic [XLEN-1:0]            mem_pc;
  logic [TAG_W-1:0]           mem_tag;
  logic                       mem_rd_flag;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_data;
  logic [XLEN-1:0]            out_pc;
  logic [TAG_W-1:0]           out_tag;
  logic                       out_src;
  logic                       out_wr_flag;
  logic                       out_rd_flag;
  logic [$clog2(DEPTH):0]     count;
`ifdef LOAD_EXT_EN
  logic [2:0]                 lsq_funct3;
  logic [2:0]                 mem_funct3;
  logic [1:0]                 lsq_addr_lo;
  logic [1:0]                 mem_addr_lo;
`endif

  modport slave (
    input  lsq_valid, lsq_data, lsq_pc, lsq_tag, lsq_wr_flag, lsq_rd_flag,
    input  mem_valid, mem_data, mem_pc, mem_tag, mem_rd_flag,
    input  out_ready,
`ifdef LOAD_EXT_EN
    input  lsq_funct3, mem_funct3, lsq_addr_lo, mem_addr_lo,
`endif
    output lsq_ready, mem_ready,
    output out_valid, out_data, out_pc, out_tag, out_src, out_wr_flag, out_rd_flag,
    output count
  );

  modport master (
    output lsq_valid, lsq_data, lsq_pc, lsq_tag, lsq_wr_flag, lsq_rd_flag,
    output mem_valid, mem_data, mem_pc, mem_tag, mem_rd_flag,
    output out_ready,
`ifdef LOAD_EXT_EN
    output lsq_funct3, mem_funct3, lsq_addr_lo, mem_addr_lo,
`endif
    input  lsq_ready, mem_ready,
    input  out_valid, out_data, out_pc, out_tag, out_src, out_wr_flag, out_rd_flag,
    input  count
  );
endinterface

// File: rtl/mem_complete_buffer.sv
// Two-source completion FIFO between the memory stage and the complete stage.
// Optional load byte/half extraction at push is enabled by defining LOAD_EXT_EN.
module mem_complete_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  mem_complete_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic             wr_flag;
    logic             rd_flag;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] free;
  logic             lsq_fire, mem_fire, pop;
  logic [PTR_W-1:0] mem_slot;
  entry_t           lsq_entry, mem_entry, head;
  logic [XLEN-1:0]  lsq_data_in, mem_data_in;

`ifdef LOAD_EXT_EN
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                               input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [XLEN-1:0] s;
    s = raw >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{(XLEN-8){s[7]}}, s[7:0]};
      3'b001:  return {{(XLEN-16){s[15]}}, s[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, s[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign lsq_data_in = load_ext(bus.lsq_data, bus.lsq_funct3, bus.lsq_addr_lo);
  assign mem_data_in = load_ext(bus.mem_data, bus.mem_funct3, bus.mem_addr_lo);
`else
  assign lsq_data_in = bus.lsq_data;
  assign mem_data_in = bus.mem_data;
`endif

  // Readies depend only on occupancy, never on out_ready.
  assign free          = CNT_W'(DEPTH) - count_q;
  assign bus.lsq_ready = rstn & ~flush & (free >= CNT_W'(1));
  assign bus.mem_ready = rstn & ~flush &
                         ((free >= CNT_W'(2)) | ((free >= CNT_W'(1)) & ~bus.lsq_valid));

  assign lsq_fire = bus.lsq_valid & bus.lsq_ready;
  assign mem_fire = bus.mem_valid & bus.mem_ready;
  assign pop      = bus.out_valid & bus.out_ready;
  assign mem_slot = wr_ptr_q + PTR_W'(lsq_fire);

  always_comb begin
    lsq_entry         = '0;
    lsq_entry.data    = lsq_data_in;
    lsq_entry.pc      = bus.lsq_pc;
    lsq_entry.tag     = bus.lsq_tag;
    lsq_entry.src     = 1'b1;
    lsq_entry.wr_flag = bus.lsq_wr_flag;
    lsq_entry.rd_flag = bus.lsq_rd_flag;

    mem_entry         = '0;
    mem_entry.data    = mem_data_in;
    mem_entry.pc      = bus.mem_pc;
    mem_entry.tag     = bus.mem_tag;
    mem_entry.src     = 1'b0;
    mem_entry.wr_flag = 1'b0;
    mem_entry.rd_flag = bus.mem_rd_flag;
  end

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (lsq_fire) entry_d[wr_ptr_q] = lsq_entry;
      if (mem_fire) entry_d[mem_slot] = mem_entry;
      wr_ptr_d = wr_ptr_q + PTR_W'(lsq_fire) + PTR_W'(mem_fire);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(lsq_fire) + CNT_W'(mem_fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every output field is gated by out_valid.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign head            = entry_q[rd_ptr_q];
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_data    = bus.out_valid ? head.data    : '0;
  assign bus.out_pc      = bus.out_valid ? head.pc      : '0;
  assign bus.out_tag     = bus.out_valid ? head.tag     : '0;
  assign bus.out_src     = bus.out_valid & head.src;
  assign bus.out_wr_flag = bus.out_valid & head.wr_flag;
  assign bus.out_rd_flag = bus.out_valid & head.rd_flag;
  assign bus.count       = count_q;
endmodule
